bit_count_multi: RTL and testbench
==================================

Name: bit_count_multi

Overview:
- Parametrised successor to the 8-bit bit-count ASMD.
- Counts set bits, clear bits, or trailing zeros of a WIDTH-bit operand, using one shift per clock with early termination.
- Uses the same start/done level handshake as the existing counter, and adds a busy flag.
- Sits between board switches/registers and the 7-seg display path in DE1_SoC-style tops.

Parameters:
- WIDTH, 8, operand width in bits (≥2).
- RW, $clog2(WIDTH+1), result width (derived, not overridden).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  level request; sampled in IDLE.
- mode  input  2  00 = count ones, 01 = count zeros, 10 = trailing-zero count, 11 = reserved (behaves as 00).
- data  input  WIDTH  operand; captured on start.
- result  output  RW  count; valid while done=1.
- done  output  1  high in DONE state.
- busy  output  1  high in COUNT state.

Behaviour:
- Reset (reset=0, async):
  - state → IDLE; A, result, mode_r → 0.
  - done=0, busy=0 immediately, without waiting for a clock edge.
- Registers:
  - A: WIDTH-bit shift register.
  - mode_r: 2-bit captured mode.
  - result: RW bits.
- States: IDLE, COUNT, DONE. Outputs are Moore: done = (state==DONE), busy = (state==COUNT).
- IDLE:
  - start=0: hold; result keeps its last value.
  - start=1 at an edge: A ← (mode==01 ? ~data : data); mode_r ← mode; result ← 0; → COUNT.
- COUNT, modes 00/01/11, one action per edge:
  - A==0: → DONE, no register change.
  - Otherwise: result ← result + A[0]; A ← A >> 1 (zero fill).
  - Cycles spent in COUNT = h+1, where h = index of highest set bit of A plus 1 (h=0 when A=0).
- COUNT, mode 10, one action per edge:
  - A==0: result ← WIDTH; → DONE.
  - Else if A[0]==1: → DONE, result unchanged.
  - Else: result ← result+1; A ← A>>1.
- DONE:
  - Holds result and done=1 while start=1. start held high never retriggers.
  - start=0 at an edge: → IDLE. done falls, result keeps its value until the next accepted start.
- data, mode and start changes during COUNT are ignored.
- Arithmetic:
  - result never exceeds WIDTH, so no overflow in RW bits.
  - No wrap: the counter increments at most WIDTH times.
- Latency: start edge k → done high after edge k+1+(COUNT cycles). Worst case is WIDTH+1 COUNT cycles.
- Reset during COUNT or DONE: state aborts to IDLE asynchronously. After release, a new start must be seen in IDLE.
- reset release coincident with start=1: start is sampled at the first edge after release.

Test Plan:
- WIDTH=8, reset low then high, data=0x5B, mode=00, start=1:
  - busy for 8 cycles.
  - done=1 after edge k+9, result=5.
  - done holds while start=1.
  - start=0 → IDLE next edge, result stays 5.
- data=0x5B, mode=01 (A=0xA4):
  - 9 COUNT cycles, result=3.
  - data=0xFF, mode=01: A=0, 1 COUNT cycle, result=0.
- mode=10:
  - data=0x58 → 4 COUNT cycles, result=3.
  - data=0x01 → result=0 after 1 COUNT cycle.
  - data=0x00 → result=8.
- data=0x00, mode=00 → result=0, done after edge k+2. data=0x80, mode=00 → result=1, 9 COUNT cycles.
- Start data=0x5B, mode=00; flip data to 0xFF and mode to 01 during COUNT:
  - result still 5.
  - Hold start high 5 cycles in DONE: no restart, busy stays 0.
- Mid-operation reset:
  - Assert reset=0 between edges during COUNT → done=0, busy=0, result=0 before the next edge.
  - Separately, WIDTH=16 instance, data=0xFFFF, mode=00 → result=16 (5-bit), 17 COUNT cycles.

Source files
------------

// File: rtl/bit_count_multi.sv
// rtl/bit_count_multi.sv - multi-mode bit counter (ones, zeros, trailing zeros), one shift per clock
module bit_count_multi #(
    parameter int  WIDTH = 8,
    localparam int RW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] data,
    output logic [RW-1:0]    result,
    output logic             done,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0]    MODE_ZEROS = 2'b01;
    localparam logic [1:0]    MODE_TZ    = 2'b10;
    localparam logic [RW-1:0] ONE        = RW'(1);
    localparam logic [RW-1:0] FULL       = RW'(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] a;
    logic [1:0]       mode_r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            a      <= '0;
            mode_r <= '0;
            result <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // Zero counting is ones counting on the inverted operand.
                        a      <= (mode == MODE_ZEROS) ? ~data : data;
                        mode_r <= mode;
                        result <= '0;
                        state  <= COUNT;
                        busy   <= 1'b1;
                    end
                end
                COUNT: begin
                    if (mode_r == MODE_TZ) begin
                        if (a == '0) begin
                            result <= FULL;
                            state  <= DONE;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                        end else if (a[0]) begin
                            state  <= DONE;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                        end else begin
                            result <= result + ONE;
                            a      <= a >> 1;
                        end
                    end else begin
                        // Stops as soon as no set bits remain above the shift point.
                        if (a == '0) begin
                            state  <= DONE;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                        end else begin
                            if (a[0]) begin
                                result <= result + ONE;
                            end
                            a <= a >> 1;
                        end
                    end
                end
                DONE: begin
                    if (!start) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_count_multi.sv
// tb/tb_bit_count_multi.sv - self-checking bench for bit_count_multi (WIDTH=8 and WIDTH=16)
module tb_bit_count_multi;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        start8 = 1'b0;
    logic [1:0]  mode8 = 2'b00;
    logic [7:0]  data8 = 8'h00;
    logic [3:0]  result8;
    logic        done8, busy8;

    logic        start16 = 1'b0;
    logic [1:0]  mode16 = 2'b00;
    logic [15:0] data16 = 16'h0000;
    logic [4:0]  result16;
    logic        done16, busy16;

    int checks = 0;
    int errors = 0;

    bit_count_multi #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .mode(mode8), .data(data8),
        .result(result8), .done(done8), .busy(busy8)
    );

    bit_count_multi #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .mode(mode16), .data(data16),
        .result(result16), .done(done16), .busy(busy16)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [1:0] mode;
        int         res;
        int         cyc;
    } vec_t;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference: result and number of COUNT cycles from the counting rules.
    task automatic model(input int w, input logic [15:0] d, input logic [1:0] m,
                         output int res, output int cyc);
        int ops[$];
        int hi;
        for (int i = 0; i < w; i++) ops.push_back((m == 2'b01) ? !d[i] : d[i]);
        res = 0;
        if (m == 2'b10) begin
            if (ops.sum() == 0) begin
                res = w;
                cyc = 1;
            end else begin
                while (ops[res] == 0) res++;
                cyc = res + 1;
            end
        end else begin
            hi = 0;
            for (int i = 0; i < w; i++) if (ops[i] != 0) begin res++; hi = i + 1; end
            cyc = hi + 1;
        end
    endtask

    task automatic op8(input logic [7:0] d, input logic [1:0] m, input int er, input int ec,
                       input int hold, input bit flip, input string nm);
        int edges = 0;
        int busy_n = 0;
        @(negedge clk);
        data8 = d; mode8 = m; start8 = 1'b1;
        while (!done8 && edges < 40) begin
            @(posedge clk); #1;
            edges++;
            if (busy8) busy_n++;
            if (flip && edges == 1) begin data8 = 8'hFF; mode8 = 2'b01; end
        end
        check({nm, " result"}, int'(result8), er);
        check({nm, " busy cycles"}, busy_n, ec);
        check({nm, " latency"}, edges, ec + 1);
        if (hold > 0) begin
            busy_n = 0;
            repeat (hold) begin
                @(posedge clk); #1;
                if (busy8 || !done8) busy_n++;
            end
            check({nm, " hold no restart"}, busy_n, 0);
            check({nm, " hold result"}, int'(result8), er);
        end
        @(negedge clk);
        start8 = 1'b0;
        @(posedge clk); #1;
        check({nm, " done drop"}, int'(done8), 0);
        check({nm, " result kept"}, int'(result8), er);
    endtask

    task automatic op16(input logic [15:0] d, input logic [1:0] m, input string nm);
        int er, ec;
        int edges = 0;
        int busy_n = 0;
        model(16, d, m, er, ec);
        @(negedge clk);
        data16 = d; mode16 = m; start16 = 1'b1;
        while (!done16 && edges < 60) begin
            @(posedge clk); #1;
            edges++;
            if (busy16) busy_n++;
        end
        check({nm, " result"}, int'(result16), er);
        check({nm, " busy cycles"}, busy_n, ec);
        @(negedge clk);
        start16 = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t vecs[$];
        int er, ec, edges;
        logic [7:0] rd;
        logic [1:0] rm;

        vecs.push_back('{8'h5B, 2'b00, 5, 8});
        vecs.push_back('{8'h5B, 2'b01, 3, 9});
        vecs.push_back('{8'hFF, 2'b01, 0, 1});
        vecs.push_back('{8'h58, 2'b10, 3, 4});
        vecs.push_back('{8'h01, 2'b10, 0, 1});
        vecs.push_back('{8'h00, 2'b10, 8, 1});
        vecs.push_back('{8'h00, 2'b00, 0, 1});
        vecs.push_back('{8'h80, 2'b00, 1, 9});
        vecs.push_back('{8'h5B, 2'b11, 5, 8});
        vecs.push_back('{8'h80, 2'b10, 7, 8});

        #2 reset = 1'b0;
        #1;
        check("reset done", int'(done8), 0);
        check("reset busy", int'(busy8), 0);
        check("reset result", int'(result8), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check("idle no start busy", int'(busy8), 0);

        op8(8'h5B, 2'b00, 5, 8, 3, 1'b0, "base");
        foreach (vecs[i]) op8(vecs[i].data, vecs[i].mode, vecs[i].res, vecs[i].cyc, 0, 1'b0,
                              $sformatf("vec%0d", i));

        op8(8'h5B, 2'b00, 5, 8, 5, 1'b1, "flip");

        for (int i = 0; i < 40; i++) begin
            rd = 8'($urandom);
            rm = 2'($urandom_range(0, 3));
            model(8, {8'h00, rd}, rm, er, ec);
            op8(rd, rm, er, ec, 0, 1'b0, $sformatf("rand%0d d=%02h m=%0d", i, rd, rm));
        end

        // Abort mid-count, then release reset while start is already high.
        @(negedge clk);
        data8 = 8'hFF; mode8 = 2'b00; start8 = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("midreset busy before", int'(busy8), 1);
        #2 reset = 1'b0;
        #1;
        check("midreset done", int'(done8), 0);
        check("midreset busy", int'(busy8), 0);
        check("midreset result", int'(result8), 0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check("release start sampled", int'(busy8), 1);
        edges = 1;
        while (!done8 && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        check("release result", int'(result8), 8);
        check("release latency", edges, 10);
        @(negedge clk) start8 = 1'b0;
        @(posedge clk); #1;

        op16(16'hFFFF, 2'b00, "w16 ffff");
        op16(16'h0000, 2'b10, "w16 tz0");
        for (int i = 0; i < 6; i++) op16(16'($urandom), 2'($urandom_range(0, 3)),
                                         $sformatf("w16 rand%0d", i));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
